// File: rtl/pwm_capture_if.sv
// Sample/measurement bundle between a PWM sample source and pwm_capture.
// The master drives the enable and sample words; the slave (the capture block)
// returns the measurement results and the single-cycle event pulses.
interface pwm_capture_if #(
   parameter int HRBITS   = 3,
   parameter int PRD_BITS = 16
);
   localparam int W     = 1 << HRBITS;
   localparam int CNT_W = PRD_BITS + HRBITS;

   logic             en;
   logic [W-1:0]     din;
   logic [CNT_W-1:0] period;
   logic [CNT_W-1:0] high_time;
   logic             valid;
   logic             timeout;
   logic             glitch;

   modport master (
      output en, din,
      input  period, high_time, valid, timeout, glitch
   );

   modport slave (
      input  en, din,
      output period, high_time, valid, timeout, glitch
   );
endinterface

// File: rtl/pwm_capture.sv
// PWM capture: measures period and high time of an incoming PWM waveform that
// arrives as 2^HRBITS samples per clock (bit 0 earliest). Results are in sample
// units, rising edge to rising edge, and are reported with a one-clock valid.
module pwm_capture #(
   parameter int HRBITS   = 3,
   parameter int PRD_BITS = 16,
   parameter int TIMEOUT  = 'hffff
) (
   input  logic           clk,
   input  logic           rst,
   pwm_capture_if.slave   bus
);
   localparam int W     = 1 << HRBITS;
   localparam int CNT_W = PRD_BITS + HRBITS;

   typedef enum logic {SEARCH, MEASURE} state_t;

   state_t              state_reg, state_next;
   logic                prev_bit_reg;
   logic [CNT_W-1:0]    per_acc_reg, per_acc_next;
   logic [CNT_W-1:0]    hi_acc_reg, hi_acc_next;
   logic [PRD_BITS-1:0] cyc_reg, cyc_next;
   logic [CNT_W-1:0]    period_reg, period_next;
   logic [CNT_W-1:0]    high_time_reg, high_time_next;
   logic                valid_reg, valid_next;
   logic                timeout_reg, timeout_next;
   logic                glitch_reg, glitch_next;

   logic [W-1:0]        rise;
   logic [W-1:0]        din_lo;
   logic                any_edge;
   logic                multi_edge;
   logic [HRBITS-1:0]   p0;
   logic [HRBITS:0]     pop_all;
   logic [HRBITS:0]     pop_lo;
   logic [HRBITS:0]     pop_hi;

   function automatic logic [HRBITS:0] popcount(input logic [W-1:0] v);
      logic [HRBITS:0] sum;
      sum = '0;
      for (int i = 0; i < W; i++) begin
         sum = sum + {{HRBITS{1'b0}}, v[i]};
      end
      return sum;
   endfunction

   // Rising-edge map: each sample compared with the one just before it; sample 0
   // looks back at the last sample of the previous word.
   genvar gi;
   generate
      for (gi = 0; gi < W; gi++) begin : g_rise
         if (gi == 0) begin : g_first
            assign rise[gi] = bus.din[gi] & ~prev_bit_reg;
         end else begin : g_rest
            assign rise[gi] = bus.din[gi] & ~bus.din[gi-1];
         end
      end
   endgenerate

   // More than one set bit in the edge map means two edges landed in one word.
   assign any_edge   = |rise;
   assign multi_edge = |(rise & (rise - W'(1)));

   // Position of the earliest rising edge in the word.
   always_comb begin
      p0 = '0;
      for (int i = W - 1; i >= 0; i--) begin
         if (rise[i]) begin
            p0 = HRBITS'(i);
         end
      end
   end

   // Samples strictly before the edge belong to the finishing cycle; the rest
   // (edge sample included) start the new one.
   generate
      for (gi = 0; gi < W; gi++) begin : g_lo
         assign din_lo[gi] = bus.din[gi] & (p0 > HRBITS'(gi));
      end
   endgenerate

   assign pop_all = popcount(bus.din);
   assign pop_lo  = popcount(din_lo);
   assign pop_hi  = pop_all - pop_lo;

   // Next-state and result logic; priority is enable, then glitch, then edge,
   // then timeout.
   always_comb begin
      state_next     = state_reg;
      per_acc_next   = per_acc_reg;
      hi_acc_next    = hi_acc_reg;
      cyc_next       = cyc_reg;
      period_next    = period_reg;
      high_time_next = high_time_reg;
      valid_next     = 1'b0;
      timeout_next   = 1'b0;
      glitch_next    = 1'b0;

      if (!bus.en) begin
         state_next = SEARCH;
      end else if (multi_edge) begin
         glitch_next = 1'b1;
         state_next  = SEARCH;
      end else if (state_reg == SEARCH) begin
         if (any_edge) begin
            state_next   = MEASURE;
            per_acc_next = CNT_W'(W) - CNT_W'(p0);
            hi_acc_next  = CNT_W'(pop_hi);
            cyc_next     = '0;
         end
      end else begin
         if (any_edge) begin
            period_next    = per_acc_reg + CNT_W'(p0);
            high_time_next = hi_acc_reg + CNT_W'(pop_lo);
            valid_next     = 1'b1;
            per_acc_next   = CNT_W'(W) - CNT_W'(p0);
            hi_acc_next    = CNT_W'(pop_hi);
            cyc_next       = '0;
         end else if (cyc_reg == PRD_BITS'(TIMEOUT - 1)) begin
            timeout_next = 1'b1;
            state_next   = SEARCH;
         end else begin
            per_acc_next = per_acc_reg + CNT_W'(W);
            hi_acc_next  = hi_acc_reg + CNT_W'(pop_all);
            cyc_next     = cyc_reg + PRD_BITS'(1);
         end
      end
   end

   // State, accumulators and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= SEARCH;
         prev_bit_reg  <= 1'b0;
         per_acc_reg   <= '0;
         hi_acc_reg    <= '0;
         cyc_reg       <= '0;
         period_reg    <= '0;
         high_time_reg <= '0;
         valid_reg     <= 1'b0;
         timeout_reg   <= 1'b0;
         glitch_reg    <= 1'b0;
      end else begin
         state_reg     <= state_next;
         prev_bit_reg  <= bus.din[W-1];
         per_acc_reg   <= per_acc_next;
         hi_acc_reg    <= hi_acc_next;
         cyc_reg       <= cyc_next;
         period_reg    <= period_next;
         high_time_reg <= high_time_next;
         valid_reg     <= valid_next;
         timeout_reg   <= timeout_next;
         glitch_reg    <= glitch_next;
      end
   end

   assign bus.period    = period_reg;
   assign bus.high_time = high_time_reg;
   assign bus.valid     = valid_reg;
   assign bus.timeout   = timeout_reg;
   assign bus.glitch    = glitch_reg;

endmodule
